// File: rtl/draw_engine.sv
// draw_engine: rasterises the wall column or the bird sprite into one VGA pixel write per cycle.
// It also keeps a record of the last wall and a sticky bird collision flag.
// Optional feature macro: DRAW_ENGINE_COLLISION_EN builds the wall record and the collision logic.
// Without it, touched is tied to 0.
module draw_engine #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned BIRD_W   = 4,
  parameter int unsigned BIRD_H   = 4,
  parameter int unsigned WALL_W   = 8,
  parameter int unsigned GAP_H    = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       sel,
  input  logic [7:0] pos_x,
  input  logic [6:0] pos_y,
  input  logic [2:0] colour,
  output logic       busy,
  output logic       done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       touched
);

  localparam logic [8:0] ScreenW   = 9'(SCREEN_W);
  localparam logic [8:0] ScreenH   = 9'(SCREEN_H);
  localparam logic [8:0] GapH      = 9'(GAP_H);
  localparam logic [8:0] BirdWLast = 9'(BIRD_W - 1);
  localparam logic [8:0] BirdHLast = 9'(BIRD_H - 1);
  localparam logic [8:0] WallWLast = 9'(WALL_W - 1);
  localparam logic [8:0] WallHLast = 9'(SCREEN_H - 1);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

  state_e     state_q, state_d;
  logic       sel_q;
  logic [7:0] px_q;
  logic [6:0] py_q;
  logic [2:0] col_q;
  logic [8:0] dx_q, dx_d, dy_q, dy_d;

  logic       accept, emit;
  logic       p_sel;
  logic [7:0] p_x;
  logic [6:0] p_y;
  logic [2:0] p_col;
  logic [8:0] w_last, h_last, sx, sy;
  logic       gap_row, pix_on;
  logic [2:0] pix_col;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // Next state, raster counters and the pixel to be registered at this edge.
  // On the accept edge the pixel source is the live inputs, so pixel 0 shows up in cycle 1.
  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    accept  = 1'b0;
    emit    = 1'b0;
    p_sel   = sel_q;
    p_x     = px_q;
    p_y     = py_q;
    p_col   = col_q;
    w_last  = sel_q ? BirdWLast : WallWLast;
    h_last  = sel_q ? BirdHLast : WallHLast;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StDraw;
          accept  = 1'b1;
          emit    = 1'b1;
          dx_d    = '0;
          dy_d    = '0;
          p_sel   = sel;
          p_x     = pos_x;
          p_y     = pos_y;
          p_col   = colour;
        end
      end
      StDraw: begin
        if (dx_q == w_last && dy_q == h_last) begin
          state_d = StDone;
        end else begin
          emit = 1'b1;
          if (dx_q == w_last) begin
            dx_d = '0;
            dy_d = dy_q + 9'd1;
          end else begin
            dx_d = dx_q + 9'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    sx      = {1'b0, p_x} + dx_d;
    sy      = p_sel ? ({2'b0, p_y} + dy_d) : dy_d;
    gap_row = (dy_d >= {2'b0, p_y}) && (dy_d < ({2'b0, p_y} + GapH));
    pix_col = (!p_sel && gap_row) ? 3'b000 : p_col;
    pix_on  = emit && (sx < ScreenW) && (sy < ScreenH);
  end

  // State, latched request and pixel output registers; pixel fields hold while plot is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      dx_q       <= '0;
      dy_q       <= '0;
      sel_q      <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      col_q      <= '0;
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour_out <= '0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      if (accept) begin
        sel_q <= sel;
        px_q  <= pos_x;
        py_q  <= pos_y;
        col_q <= colour;
      end
      plot <= pix_on;
      if (pix_on) begin
        x          <= sx[7:0];
        y          <= sy[6:0];
        colour_out <= pix_col;
      end
    end
  end

`ifdef DRAW_ENGINE_COLLISION_EN
  logic       wall_valid, hit_d, hit_q, touched_q;
  logic [7:0] wall_x;
  logic [6:0] wall_gap;
  logic [8:0] bx, by, wx, wg;
  logic       x_ovl, y_out, floor_hit;

  // Bird collision against the recorded wall and the floor, evaluated on the live request inputs.
  always_comb begin
    bx        = {1'b0, pos_x};
    by        = {2'b0, pos_y};
    wx        = {1'b0, wall_x};
    wg        = {2'b0, wall_gap};
    x_ovl     = (bx + BirdWLast >= wx) && (wx + WallWLast >= bx);
    y_out     = (by < wg) || (by + BirdHLast > wg + GapH - 9'd1);
    floor_hit = (by + 9'(BIRD_H)) > ScreenH;
    hit_d     = (wall_valid && x_ovl && y_out) || floor_hit;
  end

  // Wall record at accept; bird result held until the DRAW->DONE edge so done sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wall_valid <= 1'b0;
      wall_x     <= '0;
      wall_gap   <= '0;
      hit_q      <= 1'b0;
      touched_q  <= 1'b0;
    end else begin
      if (accept && !sel) begin
        wall_valid <= 1'b1;
        wall_x     <= pos_x;
        wall_gap   <= pos_y;
      end
      if (accept && sel) hit_q <= hit_d;
      if (state_q == StDraw && state_d == StDone && sel_q) touched_q <= touched_q | hit_q;
    end
  end

  assign touched = touched_q;
`else
  assign touched = 1'b0;
`endif

endmodule

// File: doc/draw_engine.md
# draw_engine

Pixel-generating datapath that answers the game controller's per-frame draw requests. The controller issues one request per object (the wall, then the bird); the engine rasterises a rectangle into VGA-adapter pixel writes, pulses `done` so the controller can advance to its next draw state, and returns the `touched` collision flag that the bird and wall controllers consume.

## Interface
- `SCREEN_W`, default 160: screen width in pixels.
- `SCREEN_H`, default 120: screen height in pixels.
- `BIRD_W` / `BIRD_H`, default 4 / 4: bird sprite size.
- `WALL_W`, default 8: wall column width.
- `GAP_H`, default 40: height of the wall's opening.

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `req`  in  1  start strobe; sampled only in IDLE.
- `sel`  in  1  0 = wall, 1 = bird.
- `pos_x`  in  8  left x of the object.
- `pos_y`  in  7  top y of the bird, or top row of the gap for a wall.
- `colour`  in  3  draw colour; 3'b000 erases.
- `busy`  out  1  high from accept through the DONE cycle.
- `done`  out  1  one-cycle pulse when a request completes.
- `x`  out  8  pixel x to the VGA adapter.
- `y`  out  7  pixel y to the VGA adapter.
- `colour_out`  out  3  pixel colour.
- `plot`  out  1  pixel write enable.
- `touched`  out  1  collision flag.

## Operation
- FSM states: IDLE, DRAW, DONE.
  - IDLE -> DRAW: on `req` = 1. `sel`, `pos_x`, `pos_y` and `colour` are latched on that edge.
  - DRAW -> DONE: after the last pixel is emitted.
  - DONE -> IDLE: unconditionally.
- `req` is ignored outside IDLE. Requests are never queued.
- Raster order is row-major: `dx` is the inner counter (0..W-1), `dy` the outer (0..H-1).
- Output pixel: `x` = `pos_x` + `dx`, `y` = `pos_y_base` + `dy`.
  - For a bird, `pos_y_base` = latched `pos_y`.
  - For a wall, `pos_y_base` = 0.
- Wall size: W = `WALL_W`, H = `SCREEN_H`. Rows `pos_y` .. `pos_y`+`GAP_H`-1 are emitted with colour 3'b000. All other rows use the latched `colour`.
- Bird size: W = `BIRD_W`, H = `BIRD_H`, all pixels in the latched `colour`.
- Clipping:
  - Coordinate sums are computed 9 bits wide.
  - When a sum reaches `SCREEN_W` or `SCREEN_H`, `plot` is 0 for that pixel.
  - Clipped pixels still consume their cycle, so latency is fixed.
- Wall record:
  - Every accepted wall request stores `wall_x` and `wall_gap`, and sets `wall_valid`.
  - Erase requests (`colour` = 0) also update the record.
- Collision, computed when a bird request is accepted and committed in DONE. `touched` becomes 1 if either holds:
  - `wall_valid`, the ranges [bx, bx+`BIRD_W`-1] and [`wall_x`, `wall_x`+`WALL_W`-1] intersect, and (by < `wall_gap` or by+`BIRD_H`-1 > `wall_gap`+`GAP_H`-1).
  - by+`BIRD_H` > `SCREEN_H` (the bird hits the floor).
- `touched` is sticky. Only `reset` clears it. Wall requests never change it.

## Timing
- Reset values: state IDLE; `busy`, `done`, `plot`, `touched` = 0; `x`, `y`, `colour_out` = 0; `wall_valid` = 0; `wall_x`, `wall_gap` = 0.
- Reset has priority over every other input. If asserted during DRAW, the engine is in IDLE with `plot` = 0 after that edge, and no `done` is generated.
- Accept edge is cycle 0. The first pixel (`dx` = `dy` = 0) appears registered in cycle 1 with `plot` valid.
- One pixel per cycle, so the last pixel appears in cycle W×H.
  - Bird: last pixel in cycle 16, `done` in cycle 17.
  - Wall: last pixel in cycle 960, `done` in cycle 961.
- `busy` is high in cycles 1 .. W×H+1.
- In the cycle of `done`, `touched` already shows the updated value.
- The earliest next accept is the edge ending the DONE cycle (IDLE in cycle W×H+2). A `req` held high is accepted then.
- `x`, `y`, `colour_out` hold their last values while `plot` = 0.

## Configuration
- Macro: `DRAW_ENGINE_COLLISION_EN`.
- Defined: the wall record and collision logic are built as described.
- Undefined: no wall record is built, `touched` is tied to 0, and drawing behaviour and timing are unchanged.

## Test plan
- Reset, then a bird request with `pos_x` = 10, `pos_y` = 20, `colour` = 3'b111 -> 16 plots covering x 10..13, y 20..23 in row-major order from cycle 1; `done` in cycle 17 only; `touched` = 0.
- Wall request with `pos_x` = 100, `pos_y` = 30, `colour` = 3'b010 -> 960 pixels; rows 30..69 have colour 0 and all other rows colour 2; `done` in cycle 961.
- That wall, then a bird at (102, 10) -> `touched` = 1 at `done`. With the macro undefined, `touched` stays 0.
- Bird at (102, 40) inside the gap -> `touched` stays 0. Bird at (50, 117) -> `touched` = 1 (floor).
- Wall at `pos_x` = 156 -> plot = 0 for `dx` ≥ 4. Pulsing `req` during DRAW is ignored; total latency is still 961 cycles.
- Assert `reset` at cycle 300 of a wall draw -> IDLE and `plot` = 0 at the next edge, no `done`, `touched` = 0, `wall_valid` cleared.
